// File: rtl/jtcop_prog_pack.sv
// ROM download packer: classifies ioctl bytes into SDRAM banks or PROM,
// queues up to two entries and runs the prog_we/prog_ack handshake.
module jtcop_prog_pack #(
   parameter logic [24:0] BA1_START  = 25'h8_0000,
   parameter logic [24:0] BA2_START  = 25'hC_0000,
   parameter logic [24:0] BA3_START  = 25'h20_0000,
   parameter logic [24:0] PROM_START = 25'h30_0000,
   parameter bit          SWAB       = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        downloading,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic        ioctl_wr,
   output logic [21:0] prog_addr,
   output logic [15:0] prog_data,
   output logic [1:0]  prog_mask,
   output logic [1:0]  prog_ba,
   output logic        prog_we,
   output logic        prog_rd,
   output logic        prom_we,
   input  logic        prog_ack,
   output logic        dwnld_busy
);

   typedef struct packed {
      logic        prom;
      logic [1:0]  ba;
      logic [21:0] addr;
      logic [15:0] data;
      logic [1:0]  mask;
   } ent_t;

   typedef enum logic [1:0] {IDLE, WR, PROM, GAP} st_t;

   st_t         st_q, st_d;
   ent_t        mem_q [2];
   ent_t        mem_d [2];
   logic        rd_q, rd_d, wr_q, wr_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [21:0] addr_q, addr_d;
   logic [15:0] data_q, data_d;
   logic [1:0]  mask_q, mask_d, ba_q, ba_d;
   logic        we_q, we_d, pwe_q, pwe_d, busy_q, busy_d;

   ent_t        new_e, head;
   logic [24:0] off;
   logic        push, pop, head_v, lane;
   logic        unused_off;

   assign unused_off = ^off[24:23];

   always_comb begin
      new_e = '0;
      off   = ioctl_addr;
      if (ioctl_addr >= PROM_START) begin
         new_e.prom = 1'b1;
         off        = ioctl_addr - PROM_START;
      end else if (ioctl_addr >= BA3_START) begin
         new_e.ba = 2'd3;
         off      = ioctl_addr - BA3_START;
      end else if (ioctl_addr >= BA2_START) begin
         new_e.ba = 2'd2;
         off      = ioctl_addr - BA2_START;
      end else if (ioctl_addr >= BA1_START) begin
         new_e.ba = 2'd1;
         off      = ioctl_addr - BA1_START;
      end
      lane       = off[0] ^ SWAB;
      new_e.addr = new_e.prom ? off[21:0] : off[22:1];
      new_e.data = {ioctl_dout, ioctl_dout};
      new_e.mask = lane ? 2'b01 : 2'b10;
   end

   assign push   = ioctl_wr & downloading & (cnt_q != 2'd2);
   // An empty queue forwards the incoming byte so the request leaves next cycle
   assign head   = (cnt_q == 2'd0) ? new_e : mem_q[rd_q];
   assign head_v = (cnt_q != 2'd0) | push;

   always_comb begin
      st_d   = st_q;
      addr_d = addr_q;
      data_d = data_q;
      mask_d = mask_q;
      ba_d   = ba_q;
      we_d   = we_q;
      pwe_d  = pwe_q;
      pop    = 1'b0;
      unique case (st_q)
         IDLE, GAP: begin
            st_d = IDLE;
            if (head_v) begin
               addr_d = head.addr;
               data_d = head.data;
               if (head.prom) begin
                  pwe_d = 1'b1;
                  st_d  = PROM;
               end else begin
                  mask_d = head.mask;
                  ba_d   = head.ba;
                  we_d   = 1'b1;
                  st_d   = WR;
               end
            end
         end
         WR: begin
            if (prog_ack) begin
               we_d = 1'b0;
               pop  = 1'b1;
               st_d = GAP;
            end
         end
         PROM: begin
            pwe_d = 1'b0;
            pop   = 1'b1;
            st_d  = GAP;
         end
         default: st_d = IDLE;
      endcase
   end

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      if (push) begin
         mem_d[wr_q] = new_e;
         wr_d        = ~wr_q;
      end
      if (pop) rd_d = ~rd_q;
      cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
      busy_d = (cnt_d != 2'd0) | (st_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q   <= IDLE;
         mem_q  <= '{default: '0};
         rd_q   <= 1'b0;
         wr_q   <= 1'b0;
         cnt_q  <= 2'd0;
         addr_q <= '0;
         data_q <= '0;
         mask_q <= '0;
         ba_q   <= '0;
         we_q   <= 1'b0;
         pwe_q  <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         mem_q  <= mem_d;
         rd_q   <= rd_d;
         wr_q   <= wr_d;
         cnt_q  <= cnt_d;
         addr_q <= addr_d;
         data_q <= data_d;
         mask_q <= mask_d;
         ba_q   <= ba_d;
         we_q   <= we_d;
         pwe_q  <= pwe_d;
         busy_q <= busy_d;
      end
   end

   assign prog_addr  = addr_q;
   assign prog_data  = data_q;
   assign prog_mask  = mask_q;
   assign prog_ba    = ba_q;
   assign prog_we    = we_q;
   assign prog_rd    = 1'b0;
   assign prom_we    = pwe_q;
   assign dwnld_busy = busy_q;

endmodule

// File: tb/tb_jtcop_prog_pack.sv
// Directed bench for jtcop_prog_pack with hand-computed expectations.
module tb_jtcop_prog_pack;

   logic        clk = 1'b0;
   logic        rst, downloading, ioctl_wr, prog_ack;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic [21:0] prog_addr;
   logic [15:0] prog_data;
   logic [1:0]  prog_mask, prog_ba;
   logic        prog_we, prog_rd, prom_we, dwnld_busy;

   int checks = 0;
   int errors = 0;

   jtcop_prog_pack dut (
      .clk(clk), .rst(rst), .downloading(downloading),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .ioctl_wr(ioctl_wr), .prog_addr(prog_addr),
      .prog_data(prog_data), .prog_mask(prog_mask),
      .prog_ba(prog_ba), .prog_we(prog_we), .prog_rd(prog_rd),
      .prom_we(prom_we), .prog_ack(prog_ack),
      .dwnld_busy(dwnld_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      tick();
      ioctl_wr   = 1'b0;
   endtask

   task automatic ack_once();
      prog_ack = 1'b1;
      tick();
      prog_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1; downloading = 1'b1; ioctl_wr = 1'b0; prog_ack = 1'b0;
      ioctl_addr = '0; ioctl_dout = '0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_we",   prog_we, 0);
      chk("rst_pwe",  prom_we, 0);
      chk("rst_rd",   prog_rd, 0);
      chk("rst_busy", dwnld_busy, 0);
      chk("rst_addr", prog_addr, 0);
      chk("rst_data", prog_data, 0);
      chk("rst_mask", prog_mask, 0);
      chk("rst_ba",   prog_ba, 0);

      // bank 0 byte, held until ack
      wr_byte(25'h5, 8'hAB);
      chk("b0_we",   prog_we, 1);
      chk("b0_ba",   prog_ba, 0);
      chk("b0_addr", prog_addr, 22'h2);
      chk("b0_data", prog_data, 16'hABAB);
      chk("b0_mask", prog_mask, 2'b10);
      chk("b0_busy", dwnld_busy, 1);
      tick(); tick();
      chk("b0_hold", prog_we, 1);
      chk("b0_hold_addr", prog_addr, 22'h2);
      ack_once();
      chk("b0_we_low", prog_we, 0);
      chk("b0_gap_busy", dwnld_busy, 1);
      tick();
      chk("b0_idle_busy", dwnld_busy, 0);

      // bank boundaries
      wr_byte(25'h7_FFFF, 8'h11);
      chk("b0e_ba",   prog_ba, 0);
      chk("b0e_addr", prog_addr, 22'h3_FFFF);
      chk("b0e_mask", prog_mask, 2'b10);
      ack_once(); tick();
      wr_byte(25'h8_0000, 8'h22);
      chk("b1_ba",   prog_ba, 1);
      chk("b1_addr", prog_addr, 0);
      chk("b1_mask", prog_mask, 2'b01);
      ack_once(); tick();
      wr_byte(25'hC_0002, 8'h33);
      chk("b2_ba",   prog_ba, 2);
      chk("b2_addr", prog_addr, 1);
      ack_once(); tick();
      wr_byte(25'h20_0001, 8'h44);
      chk("b3_ba",   prog_ba, 3);
      chk("b3_addr", prog_addr, 0);
      chk("b3_mask", prog_mask, 2'b10);
      chk("b3_data", prog_data, 16'h4444);
      ack_once(); tick();

      // PROM single strobe
      wr_byte(25'h30_0010, 8'h5C);
      chk("pr_pwe",  prom_we, 1);
      chk("pr_we",   prog_we, 0);
      chk("pr_addr", prog_addr, 22'h10);
      chk("pr_data", prog_data[7:0], 8'h5C);
      tick();
      chk("pr_pwe_low", prom_we, 0);
      chk("pr_busy", dwnld_busy, 1);
      tick();
      chk("pr_idle", dwnld_busy, 0);

      // back-to-back PROM strobes two cycles apart
      wr_byte(25'h30_0020, 8'h01);
      chk("pp1", prom_we, 1);
      wr_byte(25'h30_0021, 8'h02);
      chk("pp_gap", prom_we, 0);
      tick();
      chk("pp2", prom_we, 1);
      chk("pp2_addr", prog_addr, 22'h21);
      tick(); tick();
      chk("pp_idle", dwnld_busy, 0);

      // backpressure: third byte dropped
      wr_byte(25'h10, 8'h01);
      chk("bp1_addr", prog_addr, 22'h8);
      wr_byte(25'h20, 8'h02);
      wr_byte(25'h30, 8'h03);
      tick();
      chk("bp1_hold", prog_we, 1);
      ack_once();
      chk("bp_gap", prog_we, 0);
      tick();
      chk("bp2_we",   prog_we, 1);
      chk("bp2_addr", prog_addr, 22'h10);
      chk("bp2_data", prog_data, 16'h0202);
      ack_once();
      chk("bp_busy_gap", dwnld_busy, 1);
      tick();
      chk("bp_drop_busy", dwnld_busy, 0);
      chk("bp_drop_we", prog_we, 0);

      // downloading falls with an entry pending
      wr_byte(25'h40, 8'h04);
      downloading = 1'b0;
      wr_byte(25'h50, 8'h05);
      chk("dl_busy", dwnld_busy, 1);
      chk("dl_addr", prog_addr, 22'h20);
      ack_once(); tick();
      chk("dl_done", dwnld_busy, 0);
      chk("dl_ignored", prog_we, 0);
      downloading = 1'b1;

      // reset mid-write
      wr_byte(25'h60, 8'h06);
      chk("rw_we", prog_we, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rw_we0", prog_we, 0);
      chk("rw_busy0", dwnld_busy, 0);
      ack_once();
      chk("rw_ack_we", prog_we, 0);
      tick();
      chk("rw_ack_busy", dwnld_busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
